// File: rtl/lvt_ram_pkg.sv
// Shared types and the write-arbitration helper for the LVT multiport RAM.
package lvt_ram_pkg;

    localparam int MAX_PORTS  = 16;
    localparam int MAX_ADDR_W = 16;
    localparam int MAX_ID_W   = 4;
    localparam int MAX_WIDTH  = 128;

    typedef logic [MAX_ADDR_W-1:0] addr_t;
    typedef logic [MAX_ID_W-1:0]   id_t;
    typedef logic [MAX_WIDTH-1:0]  word_t;
    typedef addr_t [MAX_PORTS-1:0] addr_vec_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    typedef struct packed {
        logic hit;
        id_t  port;
    } winner_t;

    // Highest-index enabled port writing an in-range address wins it.
    function automatic winner_t find_winner(
        input addr_t                 addr,
        input logic [MAX_PORTS-1:0]  wen,
        input addr_vec_t             waddr,
        input int unsigned           n_write,
        input int unsigned           depth
    );
        winner_t w;
        w = '0;
        if (32'(addr) < depth) begin
            for (int unsigned k = 0; k < MAX_PORTS; k++) begin
                if (k < n_write && wen[k] && waddr[k] == addr) begin
                    w.hit  = 1'b1;
                    w.port = id_t'(k);
                end
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lvt_ram_bank.sv
// 1W1R distributed RAM primitive: synchronous write, asynchronous read.
module lvt_ram_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port; the caller guarantees waddr < DEPTH when we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lvt_table.sv
// Live-value table: remembers which write port last wrote each address.
module lvt_table #(
    parameter int DEPTH   = 32,
    parameter int N_WRITE = 2,
    parameter int N_READ  = 2,
    parameter int AW      = 5,
    parameter int IDW     = 1
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic [AW-1:0]                 clear_addr,
    input  logic [N_WRITE-1:0]            we,
    input  logic [N_WRITE-1:0][AW-1:0]    waddr,
    input  logic [N_READ-1:0][AW-1:0]     raddr,
    output logic [N_READ-1:0][IDW-1:0]    rid
);

    logic [IDW-1:0] mem [DEPTH];

    // Clear has priority; otherwise winning ports (distinct addresses) tag their entry.
    always_ff @(posedge clk) begin
        if (clear) begin
            mem[clear_addr] <= '0;
        end else begin
            for (int j = 0; j < N_WRITE; j++) begin
                if (we[j]) begin
                    mem[waddr[j]] <= IDW'(j);
                end
            end
        end
    end

    // Combinational lookup per read port.
    always_comb begin
        for (int i = 0; i < N_READ; i++) begin
            rid[i] = mem[raddr[i]];
        end
    end

endmodule

// File: rtl/lvt_multiport_ram.sv
// N-write/N-read RAM built from 1W1R banks plus a live-value table,
// with a post-reset clear sweep, write arbitration and optional bypass.
module lvt_multiport_ram
    import lvt_ram_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 32,
    parameter int               N_WRITE      = 2,
    parameter int               N_READ       = 2,
    parameter int               READ_LATENCY = 0,
    parameter int               BYPASS       = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE   = '0,
    localparam int              AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              IDW          = (N_WRITE > 1) ? $clog2(N_WRITE) : 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [N_WRITE-1:0]               wen,
    input  logic [N_WRITE-1:0][AW-1:0]       waddr,
    input  logic [N_WRITE-1:0][WIDTH-1:0]    wdata,
    input  logic [N_READ-1:0][AW-1:0]        raddr,
    output logic [N_READ-1:0][WIDTH-1:0]     rdata,
    output logic                             ready,
    output logic [N_WRITE-1:0]               wdrop
);

    state_e                            state_q, state_d;
    logic [AW-1:0]                     clr_ptr_q, clr_ptr_d;
    logic                              clearing;
    logic [MAX_PORTS-1:0]              wen_x;
    addr_vec_t                         waddr_x;
    winner_t                           wr_win, rd_win;
    logic [N_WRITE-1:0]                win;
    logic [N_WRITE-1:0]                bank_we;
    logic [N_WRITE-1:0][AW-1:0]        bank_waddr;
    logic [N_WRITE-1:0][WIDTH-1:0]     bank_wdata;
    logic [WIDTH-1:0]                  bank_rdata [N_READ][N_WRITE];
    logic [N_READ-1:0][IDW-1:0]        lvt_rid;
    logic [N_READ-1:0][WIDTH-1:0]      rd_comb;

    assign clearing = (state_q == CLEAR);
    assign ready    = (state_q == READY);

    // State and clear-pointer registers; reset restarts the sweep from 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Sweep one address per cycle, leave CLEAR after the last entry.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
                state_d = READY;
            end
        end
    end

    // Widen the write ports for the shared arbitration helper; writes count only once ready.
    always_comb begin
        wen_x   = '0;
        waddr_x = '0;
        for (int j = 0; j < N_WRITE; j++) begin
            wen_x[j]   = ready & wen[j];
            waddr_x[j] = addr_t'(waddr[j]);
        end
    end

    // A port commits only if it owns its address; losers and out-of-range writes are dropped.
    always_comb begin
        win    = '0;
        wdrop  = '0;
        wr_win = '0;
        for (int j = 0; j < N_WRITE; j++) begin
            wr_win   = find_winner(waddr_x[j], wen_x, waddr_x, N_WRITE, DEPTH);
            win[j]   = wen_x[j] && wr_win.hit && (wr_win.port == id_t'(j));
            wdrop[j] = wen_x[j] && !win[j];
        end
    end

    // Bank write ports are taken over by the clear sweep while clearing.
    always_comb begin
        for (int j = 0; j < N_WRITE; j++) begin
            bank_we[j]    = clearing | win[j];
            bank_waddr[j] = clearing ? clr_ptr_q : waddr[j];
            bank_wdata[j] = clearing ? INIT_VALUE : wdata[j];
        end
    end

    for (genvar i = 0; i < N_READ; i++) begin : g_rd
        for (genvar j = 0; j < N_WRITE; j++) begin : g_wr
            lvt_ram_bank #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[j]),
                .waddr (bank_waddr[j]),
                .wdata (bank_wdata[j]),
                .raddr (raddr[i]),
                .rdata (bank_rdata[i][j])
            );
        end
    end

    if (N_WRITE > 1) begin : g_lvt
        lvt_table #(
            .DEPTH   (DEPTH),
            .N_WRITE (N_WRITE),
            .N_READ  (N_READ),
            .AW      (AW),
            .IDW     (IDW)
        ) u_lvt (
            .clk        (clk),
            .clear      (clearing),
            .clear_addr (clr_ptr_q),
            .we         (win),
            .waddr      (waddr),
            .raddr      (raddr),
            .rid        (lvt_rid)
        );
    end else begin : g_no_lvt
        assign lvt_rid = '0;
    end

    // Select the live bank per read port, then apply write-first forwarding if enabled.
    always_comb begin
        rd_win = '0;
        for (int i = 0; i < N_READ; i++) begin
            rd_comb[i] = INIT_VALUE;
            if (!clearing && (32'(raddr[i]) < DEPTH)) begin
                for (int j = 0; j < N_WRITE; j++) begin
                    if (lvt_rid[i] == IDW'(j)) begin
                        rd_comb[i] = bank_rdata[i][j];
                    end
                end
                if (BYPASS != 0) begin
                    rd_win = find_winner(addr_t'(raddr[i]), wen_x, waddr_x, N_WRITE, DEPTH);
                    if (rd_win.hit) begin
                        for (int j = 0; j < N_WRITE; j++) begin
                            if (rd_win.port == id_t'(j)) begin
                                rd_comb[i] = wdata[j];
                            end
                        end
                    end
                end
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        logic [N_READ-1:0][WIDTH-1:0] rdata_p1;

        // Stage p0 -> p1: register the resolved read data.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                rdata_p1 <= {N_READ{INIT_VALUE}};
            end else begin
                rdata_p1 <= rd_comb;
            end
        end

        assign rdata = rdata_p1;
    end else begin : g_lat0
        assign rdata = rd_comb;
    end

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Scoreboard bench for lvt_multiport_ram: four configurations share one stimulus.
//   dut0: DEPTH 32, latency 0, bypass   dut1: DEPTH 32, latency 0, no bypass
//   dut2: DEPTH 32, latency 1, bypass   dut3: DEPTH 24, latency 0, bypass
module tb_lvt_multiport_ram;
    import lvt_ram_pkg::*;

    localparam logic [31:0] INIT = 32'hDEADBEEF;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic resetn;
    logic [1:0]       wen;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0][4:0]  raddr;
    logic [1:0][31:0] rdata [NDUT];
    logic             ready [NDUT];
    logic [1:0]       wdrop [NDUT];

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int unsigned cyc;
        int          sig;   // 0 rdata, 1 ready, 2 wdrop
        int          dut;
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lvt_multiport_ram #(.WIDTH(32), .DEPTH(32), .N_WRITE(2), .N_READ(2), .READ_LATENCY(0), .BYPASS(1), .INIT_VALUE(INIT))
    u_dut0 (.clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
            .rdata(rdata[0]), .ready(ready[0]), .wdrop(wdrop[0]));
    lvt_multiport_ram #(.WIDTH(32), .DEPTH(32), .N_WRITE(2), .N_READ(2), .READ_LATENCY(0), .BYPASS(0), .INIT_VALUE(INIT))
    u_dut1 (.clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
            .rdata(rdata[1]), .ready(ready[1]), .wdrop(wdrop[1]));
    lvt_multiport_ram #(.WIDTH(32), .DEPTH(32), .N_WRITE(2), .N_READ(2), .READ_LATENCY(1), .BYPASS(1), .INIT_VALUE(INIT))
    u_dut2 (.clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
            .rdata(rdata[2]), .ready(ready[2]), .wdrop(wdrop[2]));
    lvt_multiport_ram #(.WIDTH(32), .DEPTH(24), .N_WRITE(2), .N_READ(2), .READ_LATENCY(0), .BYPASS(1), .INIT_VALUE(INIT))
    u_dut3 (.clk(clk), .resetn(resetn), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
            .rdata(rdata[3]), .ready(ready[3]), .wdrop(wdrop[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int sig, input int dut, input int port,
                              input logic [31:0] val, input string name, input int unsigned dly);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sig  = sig;
        e.dut  = dut;
        e.port = port;
        e.exp  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // v_byp: bypassing 32-deep parts (dut2 shows it one cycle later); v_nob: dut1; v_d24: dut3.
    task automatic expect_rd(input int port, input logic [31:0] v_byp, input logic [31:0] v_nob,
                             input logic [31:0] v_d24, input string name);
        expect_sig(0, 0, port, v_byp, name, 0);
        expect_sig(0, 1, port, v_nob, name, 0);
        expect_sig(0, 2, port, v_byp, name, 1);
        expect_sig(0, 3, port, v_d24, name, 0);
    endtask

    task automatic expect_ready(input logic r32, input logic r24, input string name);
        for (int d = 0; d < 3; d++) expect_sig(1, d, 0, {31'd0, r32}, name, 0);
        expect_sig(1, 3, 0, {31'd0, r24}, name, 0);
    endtask

    task automatic expect_drop(input logic [1:0] d32, input logic [1:0] d24, input string name);
        for (int d = 0; d < 3; d++) expect_sig(2, d, 0, {30'd0, d32}, name, 0);
        expect_sig(2, 3, 0, {30'd0, d24}, name, 0);
    endtask

    function automatic logic [31:0] actual(input exp_t e);
        case (e.sig)
            0:       return rdata[e.dut][e.port];
            1:       return {31'd0, ready[e.dut]};
            default: return {30'd0, wdrop[e.dut]};
        endcase
    endfunction

    // Monitor: compare every expectation that falls due in this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] act;
                act = actual(sb[i]);
                n_checks++;
                if (sb[i].cyc != cyc || act !== sb[i].exp) begin
                    n_errors++;
                    $display("FAIL %s dut%0d port%0d cycle %0d: got %h expected %h",
                             sb[i].name, sb[i].dut, sb[i].port, sb[i].cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        logic [MAX_PORTS-1:0] wx;
        addr_vec_t            ax;
        winner_t              w;
        int                   addrs [7] = '{3, 7, 5, 9, 30, 12, 13};

        resetn = 1'b0;
        wen    = '0;
        waddr  = '0;
        wdata  = '0;
        raddr  = '0;
        step();
        step();
        expect_ready(1'b0, 1'b0, "ready_in_reset");
        expect_sig(0, 2, 0, INIT, "lat1_reset_value", 0);
        resetn = 1'b1;

        // First sweep: colliding writes must be ignored and never flagged.
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k < 20) begin
                wen = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
                wdata[0] = 32'h0BAD0000; wdata[1] = 32'h0BAD0001;
                expect_drop(2'b00, 2'b00, "drop_during_clear");
            end else begin
                wen = 2'b00;
            end
            expect_ready(k >= 32, k >= 24, "ready_sweep");
        end

        for (int a = 0; a < 32; a++) begin
            step();
            raddr[0] = 5'(a);
            raddr[1] = 5'(31 - a);
            expect_rd(0, INIT, INIT, INIT, "clear_value");
            expect_rd(1, INIT, INIT, INIT, "clear_value");
        end

        // Parallel writes to distinct addresses.
        step();
        wen = 2'b11; waddr[0] = 5'd3; wdata[0] = 32'h11; waddr[1] = 5'd7; wdata[1] = 32'h22;
        raddr[0] = 5'd0; raddr[1] = 5'd1;
        expect_drop(2'b00, 2'b00, "parallel_drop");
        expect_rd(0, INIT, INIT, INIT, "parallel_other");
        expect_rd(1, INIT, INIT, INIT, "parallel_other");
        step();
        wen = 2'b00; raddr[0] = 5'd3; raddr[1] = 5'd7;
        expect_rd(0, 32'h11, 32'h11, 32'h11, "parallel_r3");
        expect_rd(1, 32'h22, 32'h22, 32'h22, "parallel_r7");
        step();
        raddr[0] = 5'd7; raddr[1] = 5'd3;
        expect_rd(0, 32'h22, 32'h22, 32'h22, "parallel_r7");
        expect_rd(1, 32'h11, 32'h11, 32'h11, "parallel_r3");

        // Same-address collision: port 1 wins, port 0 is dropped.
        step();
        wen = 2'b11; waddr[0] = 5'd5; wdata[0] = 32'hAA; waddr[1] = 5'd5; wdata[1] = 32'hBB;
        raddr[0] = 5'd0; raddr[1] = 5'd5;
        expect_drop(2'b01, 2'b01, "collision_drop");
        expect_rd(0, INIT, INIT, INIT, "collision_other");
        expect_rd(1, 32'hBB, INIT, 32'hBB, "collision_bypass");
        wx = '0; ax = '0;
        wx[1:0] = wen; ax[0] = addr_t'(waddr[0]); ax[1] = addr_t'(waddr[1]);
        w = find_winner(addr_t'(5), wx, ax, 2, 32);
        n_checks++;
        if (!(w.hit === 1'b1 && w.port === id_t'(1))) begin
            n_errors++;
            $display("FAIL pkg_winner: got hit=%0b port=%0d expected hit=1 port=1", w.hit, w.port);
        end
        step();
        wen = 2'b00; raddr[0] = 5'd5; raddr[1] = 5'd5;
        expect_rd(0, 32'hBB, 32'hBB, 32'hBB, "collision_result");
        expect_rd(1, 32'hBB, 32'hBB, 32'hBB, "collision_result");
        step();
        wen = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hCC;
        raddr[0] = 5'd1; raddr[1] = 5'd2;
        expect_drop(2'b00, 2'b00, "port0_alone_drop");
        expect_rd(0, INIT, INIT, INIT, "port0_alone_other");
        step();
        wen = 2'b00; raddr[0] = 5'd5; raddr[1] = 5'd5;
        expect_rd(0, 32'hCC, 32'hCC, 32'hCC, "lvt_switch");
        expect_rd(1, 32'hCC, 32'hCC, 32'hCC, "lvt_switch");

        // Bypass / read-first / registered read.
        step();
        wen = 2'b10; waddr[1] = 5'd9; wdata[1] = 32'h55;
        raddr[0] = 5'd9; raddr[1] = 5'd9;
        expect_drop(2'b00, 2'b00, "bypass_drop");
        expect_rd(0, 32'h55, INIT, 32'h55, "bypass_same_cycle");
        expect_rd(1, 32'h55, INIT, 32'h55, "bypass_same_cycle");
        step();
        wen = 2'b00;
        expect_rd(0, 32'h55, 32'h55, 32'h55, "bypass_next_cycle");
        expect_rd(1, 32'h55, 32'h55, 32'h55, "bypass_next_cycle");

        // Address 30 is out of range only for the 24-deep part.
        step();
        wen = 2'b01; waddr[0] = 5'd30; wdata[0] = 32'h77;
        raddr[0] = 5'd30; raddr[1] = 5'd3;
        expect_drop(2'b00, 2'b01, "oob_write_drop");
        expect_rd(0, 32'h77, INIT, INIT, "oob_read_same");
        expect_rd(1, 32'h11, 32'h11, 32'h11, "oob_keep_r3");
        step();
        wen = 2'b00;
        expect_rd(0, 32'h77, 32'h77, INIT, "oob_read_next");
        expect_rd(1, 32'h11, 32'h11, 32'h11, "oob_keep_r3");
        step();
        raddr[0] = 5'd0; raddr[1] = 5'd0;

        // Reset in READY, then again at sweep pointer 10, with writes attempted during CLEAR.
        step();
        resetn = 1'b0;
        step();
        expect_ready(1'b0, 1'b0, "ready_drop");
        expect_sig(0, 2, 0, INIT, "lat1_rereset_value", 0);
        resetn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            wen = 2'b11; waddr[0] = 5'd12; wdata[0] = 32'h99; waddr[1] = 5'd13; wdata[1] = 32'h9A;
            expect_drop(2'b00, 2'b00, "drop_mid_sweep");
            expect_ready(1'b0, 1'b0, "ready_mid_sweep");
        end
        resetn = 1'b0;
        step();
        expect_ready(1'b0, 1'b0, "ready_sweep_restart");
        resetn = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k < 16) begin
                wen = 2'b11;
                expect_drop(2'b00, 2'b00, "drop_resweep");
            end else begin
                wen = 2'b00;
            end
            expect_ready(k >= 32, k >= 24, "ready_resweep");
        end
        for (int n = 0; n < 7; n++) begin
            step();
            raddr[0] = 5'(addrs[n]); raddr[1] = 5'(addrs[n]);
            expect_rd(0, INIT, INIT, INIT, "after_reset_init");
            expect_rd(1, INIT, INIT, INIT, "after_reset_init");
        end

        // Still writable after the second sweep.
        step();
        wen = 2'b01; waddr[0] = 5'd1; wdata[0] = 32'h1234;
        raddr[0] = 5'd0; raddr[1] = 5'd0;
        expect_rd(0, INIT, INIT, INIT, "post_sweep_other");
        step();
        wen = 2'b00; raddr[0] = 5'd1; raddr[1] = 5'd1;
        expect_rd(0, 32'h1234, 32'h1234, 32'h1234, "post_sweep_write");
        expect_rd(1, 32'h1234, 32'h1234, 32'h1234, "post_sweep_write");

        step();
        step();
        step();
        foreach (sb[i]) begin
            n_checks++;
            n_errors++;
            $display("FAIL unobserved %s dut%0d port%0d cycle %0d: got none expected %h",
                     sb[i].name, sb[i].dut, sb[i].port, sb[i].cyc, sb[i].exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lvt_multiport_ram.md
Name: lvt_multiport_ram

Overview:
Next-generation N-write/N-read RAM built from a live-value table (LVT).
- Storage is a bank per (read, write) port pair; an LVT records which write port last wrote each address.
- Adds to the previous generation: a post-reset clear sweep with ready handshake, selectable read latency (0/1), deterministic same-address write arbitration with per-port drop reporting, and optional write-to-read bypass.
- Used for register files and rename/ready tables in the out-of-order core.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 32, number of entries; any value ≥2, need not be a power of two
N_WRITE, 2, write ports (≥1); N_WRITE=1 removes the LVT
N_READ, 2, read ports (≥1)
READ_LATENCY, 0, 0 = combinational read; 1 = registered rdata
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
INIT_VALUE, 0, WIDTH-bit value written to every entry by the clear sweep

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  reset; synchronous, active-low
wen  in  N_WRITE  per-port write enable
waddr  in  N_WRITE x clog2(DEPTH)  write addresses
wdata  in  N_WRITE x WIDTH  write data
raddr  in  N_READ x clog2(DEPTH)  read addresses
rdata  out  N_READ x WIDTH  read data
ready  out  1  high once the clear sweep has finished
wdrop  out  N_WRITE  per-port pulse: this port's write lost arbitration in this cycle (combinational)

Behaviour:
Reset:
- While resetn=0 at a clock edge: FSM enters CLEAR, clear pointer ← 0, ready ← 0.
- Registered rdata (READ_LATENCY=1) ← INIT_VALUE.
- Reset asserted mid-sweep or mid-operation restarts the sweep from address 0.

FSM:
- CLEAR: each cycle, write INIT_VALUE into every bank at the clear pointer and set the LVT entry to port 0, then increment the pointer.
- At pointer = DEPTH-1 the FSM moves to READY next cycle. Sweep therefore takes exactly DEPTH cycles after resetn rises; ready goes high on cycle DEPTH.
- READY: terminal state until the next reset.

During CLEAR:
- wen is ignored and wdrop=0.
- rdata = INIT_VALUE for all ports. With latency 1, the INIT_VALUE is registered.

Write:
- In READY, port j with wen[j]=1 writes wdata[j] to waddr[j] in all banks of column j, and LVT[waddr[j]] ← j.
- Arbitration: if several enabled ports target the same address, the highest-index port wins. Every lower-index enabled port on that address has wdrop[j]=1, and its data is not written to the LVT or to its banks.
- Writes to distinct addresses all commit in the same cycle.
- Address ≥ DEPTH (non-power-of-two DEPTH): the write is ignored and wdrop[j]=1.

Read:
- rdata[i] = bank[i][LVT[raddr[i]]][raddr[i]].
- READ_LATENCY=0: combinational; returns the contents as of the last edge.
  - BYPASS=1: if a winning write to raddr[i] is enabled in the same cycle, its wdata is returned instead (write-first).
  - BYPASS=0: old data is returned (read-first).
- READ_LATENCY=1: the READ_LATENCY=0 result, including the bypass rule, is registered. rdata reflects raddr of the previous cycle.
- Read address ≥ DEPTH returns INIT_VALUE.

Other rules:
- N_WRITE=1: no LVT and no arbitration; wdrop is set only for an out-of-range address.
- Width rules: addresses are clog2(DEPTH) bits (minimum 1); LVT ids are clog2(N_WRITE) bits (minimum 1).

Decomposition:
- Package lvt_ram_pkg holds:
  - addr/word/id typedef helpers
  - the function computing the winning port for an address given wen/waddr, used by both RTL and the bench scoreboard
  - FSM state enum {CLEAR, READY}
- Sub-module lvt_table: DEPTH x id storage with N_WRITE write ports, N_READ combinational read ports, and a clear input forcing the addressed entry to 0.
- Data banks reuse the existing 1W1R distributed RAM primitive.

Test Plan:
- Clear sweep: DEPTH=32, release resetn → ready=0 for cycles 0..31 and 1 at cycle 32; read every address → INIT_VALUE (set to 0xDEADBEEF).
- Parallel writes: port0 writes 0x11 to addr 3 and port1 writes 0x22 to addr 7 in the same cycle → next cycle raddr 3 → 0x11 and raddr 7 → 0x22 on both read ports; wdrop=00.
- Collision: ports 0 and 1 both write addr 5 (0xAA, 0xBB) → wdrop=01 that cycle; addr 5 subsequently reads 0xBB. Then port0 alone writes 0xCC to addr 5 → LVT switches and reads return 0xCC.
- Bypass vs latency:
  - READ_LATENCY=0, BYPASS=1: port1 writes 0x55 to addr 9 while raddr 9 is presented → same-cycle rdata=0x55.
  - BYPASS=0: same stimulus → old value that cycle, 0x55 next cycle.
  - READ_LATENCY=1: same stimulus → 0x55 one cycle later.
- Reset mid-sweep and mid-operation: assert resetn=0 at sweep pointer 10 and again after writes in READY → ready drops; a full DEPTH-cycle sweep reruns; all prior data reads as INIT_VALUE; writes during CLEAR are ignored.
- Non-power-of-two: DEPTH=24, write to addr 30 → wdrop=1, no entry changes; raddr 30 → INIT_VALUE.
